// File: rtl/pipe_ctrl_pkg.sv
// Shared types, constants and helpers for the pipeline hazard controller.
// Holds the FSM state encoding, forwarding select codes and the per-state control decode.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    HOLD     = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_br;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  // A write to register zero never creates a dependency.
  function automatic logic raw_hit(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return we && (dst != REG_ZERO) && (dst == src);
  endfunction

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      RUN: begin
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
      end
      LU_STALL: begin
        c.id_ex_en    = 1'b1;
        c.ex_mem_en   = 1'b1;
        c.mem_wb_en   = 1'b1;
        c.id_ex_flush = 1'b1;
      end
      BR_FLUSH: begin
        c.pc_en        = 1'b1;
        c.pc_sel_br    = 1'b1;
        c.if_id_en     = 1'b1;
        c.id_ex_en     = 1'b1;
        c.ex_mem_en    = 1'b1;
        c.mem_wb_en    = 1'b1;
        c.if_id_flush  = 1'b1;
        c.id_ex_flush  = 1'b1;
        c.ex_mem_flush = 1'b1;
      end
      HOLD: begin
        c = '0;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding compare for both EX source registers.
// EX/MEM results take priority over MEM/WB; register zero is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] pick(input logic [4:0] src,
                                      input logic [4:0] m_rd, input logic m_we,
                                      input logic [4:0] w_rd, input logic w_we);
    logic [1:0] sel;
    if (raw_hit(src, m_rd, m_we)) begin
      sel = FWD_MEM;
    end else if (raw_hit(src, w_rd, w_we)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Operand source selection; with forwarding disabled both operands read the register file.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FWD_EN) begin
      fwd_a = pick(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      fwd_b = pick(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end else begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline: hazard FSM, registered
// Moore buffer controls, forwarding selects and stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_branch,
  input  logic             mem_zf,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             pc_sel_br,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           next_state_s;
  ctrl_t            ctrl_r;
  ctrl_t            next_ctrl_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             load_use_s;
  logic             raw_any_s;
  logic             hazard_s;
  logic             branch_taken_s;
  logic             stall_cycle_s;

  // Hazard detection; without forwarding any pending write to an ID source must stall.
  always_comb begin
    load_use_s = ex_mem_read &
                 (raw_hit(id_rs, ex_rd, ex_reg_write) | raw_hit(id_rt, ex_rd, ex_reg_write));
    raw_any_s  = raw_hit(id_rs, ex_rd, ex_reg_write)   | raw_hit(id_rt, ex_rd, ex_reg_write) |
                 raw_hit(id_rs, mem_rd, mem_reg_write) | raw_hit(id_rt, mem_rd, mem_reg_write);
    if (FWD_EN) begin
      hazard_s = load_use_s;
    end else begin
      hazard_s = load_use_s | raw_any_s;
    end
  end

  assign branch_taken_s = mem_branch & mem_zf;
  assign stall_cycle_s  = (state_r == LU_STALL) || (state_r == HOLD);

  // Next-state priority: memory wait freezes everything, and a taken branch beats a
  // load-use stall because the stalled instruction is on the wrong path.
  always_comb begin
    next_state_s = RUN;
    if (mem_wait) begin
      next_state_s = HOLD;
    end else if (branch_taken_s) begin
      next_state_s = BR_FLUSH;
    end else if (hazard_s) begin
      next_state_s = LU_STALL;
    end else begin
      next_state_s = RUN;
    end
  end

  assign next_ctrl_s = state_ctrl(next_state_s);

  // State register with the matching Moore controls registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      ctrl_r  <= state_ctrl(RUN);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= next_ctrl_s;
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_cycle_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (next_state_s == BR_FLUSH) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  fwd_unit #(
    .FWD_EN(FWD_EN)
  ) u_fwd (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  assign pc_en        = ctrl_r.pc_en;
  assign pc_sel_br    = ctrl_r.pc_sel_br;
  assign if_id_en     = ctrl_r.if_id_en;
  assign id_ex_en     = ctrl_r.id_ex_en;
  assign ex_mem_en    = ctrl_r.ex_mem_en;
  assign mem_wb_en    = ctrl_r.mem_wb_en;
  assign if_id_flush  = ctrl_r.if_id_flush;
  assign id_ex_flush  = ctrl_r.id_ex_flush;
  assign ex_mem_flush = ctrl_r.ex_mem_flush;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares
// one entry after every rising edge. DUT a: defaults; DUT b: CNT_W=4, FWD_EN=0.
module tb_pipeline_hazard_ctrl;

  localparam logic [8:0] C_RUN  = 9'b1_0_1111_000;
  localparam logic [8:0] C_LU   = 9'b0_0_0111_010;
  localparam logic [8:0] C_BR   = 9'b1_1_1111_111;
  localparam logic [8:0] C_HOLD = 9'b0_0_0000_000;

  typedef struct {
    logic [95:0] tag;
    bit          dut;
    logic [8:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic ex_mem_read, ex_reg_write, mem_reg_write, mem_branch, mem_zf, wb_reg_write, mem_wait;
  logic stim_done = 1'b0;

  logic pc_en_a, pc_sel_br_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
  logic if_id_flush_a, id_ex_flush_a, ex_mem_flush_a;
  logic [1:0] fwd_a_a, fwd_b_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;

  logic pc_en_b, pc_sel_br_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
  logic if_id_flush_b, id_ex_flush_b, ex_mem_flush_b;
  logic [1:0] fwd_a_b, fwd_b_b;
  logic [3:0] stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut_a (
    .clk(clk), .rst(rst_a), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_branch(mem_branch), .mem_zf(mem_zf), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_wait(mem_wait), .pc_en(pc_en_a), .pc_sel_br(pc_sel_br_a),
    .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a), .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
    .fwd_a(fwd_a_a), .fwd_b(fwd_b_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .FWD_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst_b), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_branch(mem_branch), .mem_zf(mem_zf), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_wait(mem_wait), .pc_en(pc_en_b), .pc_sel_br(pc_sel_br_b),
    .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b), .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
    .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_reg_write = 1'b0;
    mem_branch = 1'b0; mem_zf = 1'b0; wb_reg_write = 1'b0; mem_wait = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
  endtask

  task automatic step(input logic [95:0] tag, input bit dut, input logic [8:0] ctrl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.tag = tag; e.dut = dut; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit after it.
  initial begin : monitor
    exp_t e;
    logic [8:0]  act_ctrl;
    logic [3:0]  act_fwd;
    logic [63:0] act_cnt;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut) begin
          act_ctrl = {pc_en_b, pc_sel_br_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b,
                      if_id_flush_b, id_ex_flush_b, ex_mem_flush_b};
          act_fwd  = {fwd_a_b, fwd_b_b};
          act_cnt  = {28'd0, stall_cnt_b, 28'd0, flush_cnt_b};
        end else begin
          act_ctrl = {pc_en_a, pc_sel_br_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a,
                      if_id_flush_a, id_ex_flush_a, ex_mem_flush_a};
          act_fwd  = {fwd_a_a, fwd_b_a};
          act_cnt  = {stall_cnt_a, flush_cnt_a};
        end
        checks++;
        if (act_ctrl !== e.ctrl) begin
          failures++;
          $display("FAIL %0s ctrl got=%b expected=%b", e.tag, act_ctrl, e.ctrl);
        end
        checks++;
        if (act_fwd !== {e.fa, e.fb}) begin
          failures++;
          $display("FAIL %0s fwd got=%b expected=%b", e.tag, act_fwd, {e.fa, e.fb});
        end
        checks++;
        if (act_cnt !== {e.sc, e.fc}) begin
          failures++;
          $display("FAIL %0s cnt got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.tag, act_cnt[63:32], act_cnt[31:0], e.sc, e.fc);
        end
      end else if (stim_done) begin
        break;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  // Directed stimulus with hand-computed expectations.
  initial begin : stimulus
    clear_inputs();
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    step("rst0", 1'b0, C_RUN, 2'b00, 2'b00, 32'd0, 32'd0);
    step("rst1", 1'b0, C_RUN, 2'b00, 2'b00, 32'd0, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step("run", 1'b0, C_RUN, 2'b00, 2'b00, 32'd0, 32'd0);

    set_load_use();
    step("lu", 1'b0, C_LU, 2'b00, 2'b00, 32'd0, 32'd0);
    clear_inputs();
    step("lu_end", 1'b0, C_RUN, 2'b00, 2'b00, 32'd1, 32'd0);

    set_load_use();
    mem_branch = 1'b1; mem_zf = 1'b1;
    step("br", 1'b0, C_BR, 2'b00, 2'b00, 32'd1, 32'd1);
    clear_inputs();
    step("br_end", 1'b0, C_RUN, 2'b00, 2'b00, 32'd1, 32'd1);

    mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    ex_rs = 5'd5; ex_rt = 5'd7;
    step("fwd_mem", 1'b0, C_RUN, 2'b10, 2'b00, 32'd1, 32'd1);
    mem_reg_write = 1'b0; ex_rt = 5'd5;
    step("fwd_wb", 1'b0, C_RUN, 2'b01, 2'b01, 32'd1, 32'd1);
    mem_reg_write = 1'b1; ex_rs = 5'd0;
    step("fwd_zero", 1'b0, C_RUN, 2'b00, 2'b10, 32'd1, 32'd1);

    clear_inputs();
    set_load_use();
    step("lu2", 1'b0, C_LU, 2'b00, 2'b00, 32'd1, 32'd1);
    rst_a = 1'b1;
    step("rst_mid", 1'b0, C_RUN, 2'b00, 2'b00, 32'd0, 32'd0);
    rst_a = 1'b0;
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, C_HOLD, 2'b00, 2'b00, 32'(i), 32'd0);
    end
    mem_wait = 1'b0;
    step("hold_lu", 1'b0, C_LU, 2'b00, 2'b00, 32'd3, 32'd0);
    clear_inputs();
    step("hold_end", 1'b0, C_RUN, 2'b00, 2'b00, 32'd4, 32'd0);

    rst_b = 1'b1;
    step("b_rst", 1'b1, C_RUN, 2'b00, 2'b00, 32'd0, 32'd0);
    rst_b = 1'b0;
    mem_rd = 5'd3; mem_reg_write = 1'b1; id_rt = 5'd3; ex_rt = 5'd3;
    step("b_raw_mem", 1'b1, C_LU, 2'b00, 2'b00, 32'd0, 32'd0);
    clear_inputs();
    step("b_run", 1'b1, C_RUN, 2'b00, 2'b00, 32'd1, 32'd0);
    ex_rd = 5'd4; ex_reg_write = 1'b1; id_rs = 5'd4;
    step("b_raw_ex", 1'b1, C_LU, 2'b00, 2'b00, 32'd1, 32'd0);
    clear_inputs();
    step("b_run2", 1'b1, C_RUN, 2'b00, 2'b00, 32'd2, 32'd0);
    mem_wait = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step("b_hold", 1'b1, C_HOLD, 2'b00, 2'b00, 32'(i + 1), 32'd0);
    end
    mem_wait = 1'b0;
    step("b_wrap", 1'b1, C_RUN, 2'b00, 2'b00, 32'd0, 32'd0);

    stim_done = 1'b1;
  end

endmodule
